// File: rtl/keypad_pkg.sv
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared types and helpers for the matrix keypad scanner.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED   = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_RELEASE_DB = 2'd3
    } key_state_t;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_MULTI  = 2'd2
    } scan_class_t;

    function automatic int code_width(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_col_sync.sv
// ============================================================================
//  Module   : keypad_col_sync
//  Purpose  : Two-flop synchroniser for the asynchronous column returns.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_col_sync
    import keypad_pkg::*;
#(
    parameter int COLS = 4
) (
    input  logic            clk_1kHz,
    input  logic            i_rst_n,
    input  logic [COLS-1:0] i_col,
    output logic [COLS-1:0] o_col_sync
);

    logic [COLS-1:0] r_meta;
    logic [COLS-1:0] r_sync;

    // Idle level is all ones: columns are active-low.
    always_ff @(posedge clk_1kHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_col;
            r_sync <= r_meta;
        end
    end

    assign o_col_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
//  Module   : keypad_scanner
//  Purpose  : Row-strobed matrix keypad reader with scan-level debounce.
//             Define KEYPAD_REPEAT_EN to enable auto-repeat of held keys.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int ROW_DWELL      = 3,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int REPEAT_DELAY   = 40,
    parameter int REPEAT_PERIOD  = 8,
    localparam int CODE_W        = code_width(ROWS, COLS)
) (
    input  logic              clk_1kHz,
    input  logic              i_rst_n,
    input  logic [COLS-1:0]   i_col,
    output logic [ROWS-1:0]   o_row,
    output logic [CODE_W-1:0] o_key_code,
    output logic              o_key_valid,
    output logic              o_key_held
);

    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DWELL_W = $clog2(ROW_DWELL + 1);
    localparam int DB_W    = $clog2(DEBOUNCE_SCANS + 1);

    logic [COLS-1:0]   w_col_sync;
    logic [ROWS-1:0]   r_row_n;
    logic [ROW_W-1:0]  r_row_idx;
    logic [DWELL_W-1:0] r_dwell;
    logic [COLS-1:0]   r_snap [ROWS];
    logic              r_eos;

    logic [1:0]        w_hits;
    logic [CODE_W-1:0] w_code;
    scan_class_t       w_cls;
    logic              w_match;
    logic              w_rpt_fire;

    key_state_t        r_state;
    logic [CODE_W-1:0] r_cand;
    logic [DB_W-1:0]   r_cnt;
    logic [CODE_W-1:0] r_key_code;
    logic              r_key_valid;
    logic              r_key_held;

    keypad_col_sync #(.COLS(COLS)) u_col_sync (
        .clk_1kHz   (clk_1kHz),
        .i_rst_n    (i_rst_n),
        .i_col      (i_col),
        .o_col_sync (w_col_sync)
    );

    // All-ones strobe only exists in reset, so it marks the first scan edge.
    always_ff @(posedge clk_1kHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row_n   <= '1;
            r_row_idx <= '0;
            r_dwell   <= '0;
            r_eos     <= 1'b0;
            for (int r = 0; r < ROWS; r++) r_snap[r] <= '1;
        end else begin
            r_eos <= 1'b0;
            if (&r_row_n) begin
                r_row_n <= ~ROWS'(1);
            end else if (r_dwell == DWELL_W'(ROW_DWELL - 1)) begin
                r_snap[r_row_idx] <= w_col_sync;
                r_dwell           <= '0;
                if (r_row_idx == ROW_W'(ROWS - 1)) begin
                    r_row_idx <= '0;
                    r_row_n   <= ~ROWS'(1);
                    r_eos     <= 1'b1;
                end else begin
                    r_row_idx <= r_row_idx + 1'b1;
                    r_row_n   <= ~(ROWS'(1) << (r_row_idx + 1'b1));
                end
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    // Descending walk leaves the lowest pressed code in w_code.
    always_comb begin
        w_hits = 2'd0;
        w_code = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            for (int c = COLS - 1; c >= 0; c--) begin
                if (!r_snap[r][c]) begin
                    w_code = CODE_W'(r * COLS + c);
                    if (w_hits != 2'd2) w_hits = w_hits + 2'd1;
                end
            end
        end
        if (w_hits == 2'd0)      w_cls = CLS_NONE;
        else if (w_hits == 2'd1) w_cls = CLS_SINGLE;
        else                     w_cls = CLS_MULTI;
    end

    assign w_match = (w_cls == CLS_SINGLE) && (w_code == r_key_code);

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] r_rpt_cnt;
    logic             r_rpt_first;

    assign w_rpt_fire = r_eos && (r_state == ST_PRESSED) && w_match &&
                        (r_rpt_cnt == (r_rpt_first ? RPT_W'(REPEAT_DELAY - 1)
                                                   : RPT_W'(REPEAT_PERIOD - 1)));

    // Cleared outside the held states, frozen while a release is debouncing.
    always_ff @(posedge clk_1kHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
        end else if (r_state == ST_RELEASED || r_state == ST_PRESS_DB) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
        end else if (r_eos && r_state == ST_PRESSED && w_match) begin
            if (w_rpt_fire) begin
                r_rpt_cnt   <= '0;
                r_rpt_first <= 1'b0;
            end else begin
                r_rpt_cnt <= r_rpt_cnt + 1'b1;
            end
        end
    end
`else
    // Repeat timing parameters are kept in the interface but have no effect here.
    assign w_rpt_fire = (REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0);
`endif

    always_ff @(posedge clk_1kHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_RELEASED;
            r_cand      <= '0;
            r_cnt       <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (r_eos) begin
                case (r_state)
                    ST_RELEASED: begin
                        if (w_cls == CLS_SINGLE) begin
                            r_state <= ST_PRESS_DB;
                            r_cand  <= w_code;
                            r_cnt   <= DB_W'(1);
                        end
                    end
                    ST_PRESS_DB: begin
                        if (w_cls != CLS_SINGLE) begin
                            r_state <= ST_RELEASED;
                            r_cnt   <= '0;
                        end else if (w_code != r_cand) begin
                            r_cand <= w_code;
                            r_cnt  <= DB_W'(1);
                        end else if (r_cnt == DB_W'(DEBOUNCE_SCANS - 1)) begin
                            r_state     <= ST_PRESSED;
                            r_key_code  <= r_cand;
                            r_key_valid <= 1'b1;
                            r_key_held  <= 1'b1;
                            r_cnt       <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        if (!w_match) begin
                            r_state <= ST_RELEASE_DB;
                            r_cnt   <= DB_W'(1);
                        end else begin
                            r_key_valid <= w_rpt_fire;
                        end
                    end
                    ST_RELEASE_DB: begin
                        if (w_match) begin
                            r_state <= ST_PRESSED;
                            r_cnt   <= '0;
                        end else if (r_cnt == DB_W'(DEBOUNCE_SCANS - 1)) begin
                            r_state    <= ST_RELEASED;
                            r_key_held <= 1'b0;
                            r_cnt      <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_RELEASED;
                endcase
            end
        end
    end

    assign o_row       = r_row_n;
    assign o_key_code  = r_key_code;
    assign o_key_valid = r_key_valid;
    assign o_key_held  = r_key_held;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
//  Module   : tb_keypad_scanner
//  Purpose  : Self-checking bench for keypad_scanner (default build).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_keypad_scanner;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DWELL = 3;
    localparam int DB    = 3;
    localparam int SCAN  = ROWS * DWELL;
    localparam int NKEYS = ROWS * COLS;

    logic             clk_1kHz = 1'b0;
    logic             i_rst_n  = 1'b0;
    logic [COLS-1:0]  i_col;
    logic [ROWS-1:0]  o_row;
    logic [3:0]       o_key_code;
    logic             o_key_valid;
    logic             o_key_held;

    logic [NKEYS-1:0] keys = '0;

    int n_checks = 0;
    int n_pass   = 0;

    int          cycle = 0;
    int          pulses = 0;
    logic [3:0]  last_pulse_code = '0;
    int          last_pulse_cyc = 0;
    int          held_fall_cyc = 0;
    logic        held_prev = 1'b0;

    bit          m_held;
    logic [3:0]  m_code;
    bit          m_pend;
    int          m_cand, m_streak, m_rel;
    int          exp_pulses;
    logic [NKEYS-1:0] prev_keys;
    bit          have_prev;

    keypad_scanner dut (
        .clk_1kHz    (clk_1kHz),
        .i_rst_n     (i_rst_n),
        .i_col       (i_col),
        .o_row       (o_row),
        .o_key_code  (o_key_code),
        .o_key_valid (o_key_valid),
        .o_key_held  (o_key_held)
    );

    always #5 clk_1kHz = ~clk_1kHz;

    // Physical keypad: a pressed key shorts its column to its row strobe.
    always_comb begin
        i_col = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!o_row[r] && keys[r*COLS + c]) i_col[c] = 1'b0;
    end

    always @(posedge clk_1kHz) cycle++;

    always @(negedge clk_1kHz) begin
        if (o_key_valid === 1'b1) begin
            pulses++;
            last_pulse_code = o_key_code;
            last_pulse_cyc  = cycle;
        end
        if (held_prev === 1'b1 && o_key_held === 1'b0) held_fall_cyc = cycle;
        held_prev = o_key_held;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int lowest_key(input logic [NKEYS-1:0] k);
        for (int i = 0; i < NKEYS; i++) if (k[i]) return i;
        return -1;
    endfunction

    // Reference: one call per completed scan, from the set of keys held during it.
    task automatic model_scan(input logic [NKEYS-1:0] k);
        int n, c;
        n = $countones(k);
        c = lowest_key(k);
        if (!m_held) begin
            if (n == 1) begin
                if (m_pend && m_cand == c) m_streak++;
                else begin
                    m_pend = 1; m_cand = c; m_streak = 1;
                end
                if (m_streak == DB) begin
                    m_held = 1; m_code = 4'(c); m_pend = 0; m_rel = 0;
                    exp_pulses++;
                end
            end else begin
                m_pend = 0;
            end
        end else begin
            if (n == 1 && c == int'(m_code)) m_rel = 0;
            else begin
                m_rel++;
                if (m_rel == DB) begin
                    m_held = 0; m_rel = 0;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_held = 0; m_code = '0; m_pend = 0; m_cand = 0; m_streak = 0; m_rel = 0;
        exp_pulses = 0; pulses = 0; have_prev = 0; prev_keys = '0;
    endtask

    task automatic sync_scan();
        bit found = 0;
        for (int i = 0; i < 3 * SCAN; i++) begin
            @(posedge clk_1kHz); #1;
            if (o_row === 4'b1110) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            $display("FAIL sync: observed no row-0 strobe, expected 1110 within %0d cycles", 3 * SCAN);
            $fatal(1);
        end
    endtask

    // Called just after a row-0 strobe edge; returns just after the next one.
    task automatic run_scan(input logic [NKEYS-1:0] k);
        logic [3:0] erow;
        keys = k;
        chk("row", 32'(o_row), 32'(4'b1110));
        for (int cyc = 1; cyc < SCAN; cyc++) begin
            @(posedge clk_1kHz); #1;
            erow = ~(4'b0001 << (cyc / DWELL));
            chk("row", 32'(o_row), 32'(erow));
            if (cyc == 2) begin
                if (have_prev) model_scan(prev_keys);
                chk("pulse_count", pulses, exp_pulses);
                chk("held", 32'(o_key_held), 32'(m_held));
                chk("code", 32'(o_key_code), 32'(m_code));
                if (exp_pulses > 0) chk("pulse_code", 32'(last_pulse_code), 32'(m_code));
            end
        end
        prev_keys = k;
        have_prev = 1;
        @(posedge clk_1kHz); #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_row"},   32'(o_row),       32'(4'b1111));
        chk({tag, "_code"},  32'(o_key_code),  32'd0);
        chk({tag, "_valid"}, 32'(o_key_valid), 32'd0);
        chk({tag, "_held"},  32'(o_key_held),  32'd0);
    endtask

    initial begin
        int t0, seg_type, dur, ka, kb;
        logic [NKEYS-1:0] pat;

        model_reset();
        repeat (3) @(posedge clk_1kHz);
        #1;
        check_reset_values("reset");
        @(negedge clk_1kHz);
        i_rst_n = 1'b1;
        sync_scan();

        // Idle scans: row sequencing only.
        repeat (3) run_scan('0);

        // Press and hold key 6 (row 1, col 2), then release.
        t0 = cycle;
        repeat (9) run_scan(NKEYS'(1) << 6);
        chk("press_latency_ok", 32'((last_pulse_cyc - t0) >= 36 && (last_pulse_cyc - t0) <= 48), 32'd1);
        t0 = cycle;
        repeat (5) run_scan('0);
        chk("release_latency_ok", 32'((held_fall_cyc - t0) >= 36 && (held_fall_cyc - t0) <= 48), 32'd1);

        // Bounce on key 9, then settle.
        for (int i = 0; i < 4; i++) run_scan((i % 2 == 0) ? (NKEYS'(1) << 9) : '0);
        repeat (5) run_scan(NKEYS'(1) << 9);
        repeat (4) run_scan('0);

        // Two keys together, then only key 0.
        repeat (9) run_scan((NKEYS'(1) << 0) | (NKEYS'(1) << 5));
        repeat (5) run_scan(NKEYS'(1) << 0);
        repeat (4) run_scan('0);

        // Reset two scans into a press of key 15.
        repeat (2) run_scan(NKEYS'(1) << 15);
        repeat (5) @(posedge clk_1kHz);
        #1;
        i_rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        keys = '0;
        repeat (2) @(posedge clk_1kHz);
        #1;
        check_reset_values("held_reset");
        @(negedge clk_1kHz);
        i_rst_n = 1'b1;
        model_reset();
        sync_scan();
        run_scan('0);
        repeat (5) run_scan(NKEYS'(1) << 15);
        repeat (4) run_scan('0);

        // Randomised segments: none, single, two keys, same-key reorders.
        for (int s = 0; s < 60; s++) begin
            seg_type = $urandom_range(0, 3);
            dur      = $urandom_range(1, 6);
            ka       = $urandom_range(0, NKEYS - 1);
            kb       = (ka + $urandom_range(1, NKEYS - 1)) % NKEYS;
            case (seg_type)
                0:       pat = '0;
                1, 3:    pat = NKEYS'(1) << ka;
                default: pat = (NKEYS'(1) << ka) | (NKEYS'(1) << kb);
            endcase
            repeat (dur) run_scan(pat);
        end
        repeat (5) run_scan('0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
